mbinit_substate_sequencer: RTL and testbench
============================================

Name: mbinit_substate_sequencer

Overview:
- Top-level controller for the MBINIT training state. Steps the six MBINIT substate modules in a fixed order: PARAM, CAL, REPAIRCLK, REPAIRVAL, REVERSALMB, REPAIRMB.
- Drives their level enables and watches their end and error flags.
- Enforces a per-substate timeout.
- Multiplexes the active substate's sideband TX message onto the single shared sideband transmit path.
- Reports MBINIT done or training error to the LTSM top.

Parameters:
- NUM_SUB, 6, number of substates (fixed order, index 0 = PARAM).
- TIMEOUT_CYCLES, 800000, per-substate timeout in CLK cycles (8 ms at 100 MHz).

Ports:
- CLK  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- i_mbinit_en  in  1  level; LTSM is in MBINIT. Low aborts everything.
- i_sub_end  in  NUM_SUB  level end flag from each substate module.
- i_sub_err  in  NUM_SUB  train-error request from each substate module.
- i_sub_tx_msg  in  4*NUM_SUB  packed 4-bit sideband message per substate (slice k = bits 4k+3:4k).
- i_sub_tx_valid  in  NUM_SUB  sideband message valid per substate.
- o_sub_en  out  NUM_SUB  thermometer enable to the substates.
- o_tx_msg  out  4  muxed sideband message.
- o_tx_valid  out  1  muxed sideband valid.
- o_active_sub  out  3  index of the running substate.
- o_mbinit_done  out  1  all substates completed.
- o_train_error  out  1  MBINIT failed (error or timeout).

Behaviour:
- Reset (synchronous, rst_n low at a CLK edge):
  - state = IDLE, timeout counter = 0.
  - All outputs 0: o_sub_en=0, o_tx_msg=0, o_tx_valid=0, o_active_sub=0, o_mbinit_done=0, o_train_error=0.
  - Reset mid-operation aborts immediately; no end or error flags are produced.
- All outputs are registered and decoded from the next state. Outputs change on the same edge as the state.
- States: IDLE, RUN(k) with k = 0..NUM_SUB-1, DONE, ERROR.
- IDLE -> RUN(0) when i_mbinit_en = 1. o_sub_en = 000001 from the next edge.
- RUN(k):
  - o_sub_en[j] = 1 for all j <= k (thermometer).
  - Completed substates stay enabled so their held end flags gate the next module.
  - o_active_sub = k.
- RUN(k) -> RUN(k+1) when i_sub_end[k] = 1. Counter clears on entry to RUN(k+1).
- RUN(NUM_SUB-1) -> DONE when i_sub_end[NUM_SUB-1] = 1.
- RUN(k) -> ERROR when any of the following holds:
  - any i_sub_err[j] = 1 with j <= k; or
  - i_sub_end[j] drops to 0 for some j < k (a completed substate regressed); or
  - the timeout counter reaches TIMEOUT_CYCLES-1.
- Precedence in the same cycle: i_mbinit_en low > error/timeout > end. If end and error are both high, the next state is ERROR.
- i_sub_end[j] and i_sub_err[j] with j > k are ignored.
- DONE:
  - o_sub_en all 1, o_mbinit_done = 1.
  - Held until i_mbinit_en = 0, then IDLE.
- ERROR:
  - o_sub_en = 0, o_train_error = 1.
  - Held until i_mbinit_en = 0, then IDLE.
- i_mbinit_en = 0 in any state -> IDLE next edge, all outputs 0.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES).
  - Increments every cycle in RUN(k); saturates and never wraps.
  - Cleared in IDLE/DONE/ERROR and on every substate advance.
- TX mux:
  - In RUN(k), o_tx_msg = i_sub_tx_msg slice k and o_tx_valid = i_sub_tx_valid[k], registered with 1 cycle latency.
  - Valid from non-active substates is dropped.
  - Outside RUN, o_tx_msg = 0 and o_tx_valid = 0.
  - On the advance edge RUN(k) -> RUN(k+1), the mux selects k+1.

Optional Feature:
- Macro: MBINIT_SEQ_TIMEOUT_EN.
- Defined: the timeout counter and its transition to ERROR exist as described above.
- Undefined: no counter logic; RUN(k) waits indefinitely. ERROR is reached only via i_sub_err or end-flag regression. TIMEOUT_CYCLES is unused.

Decomposition:
- Shared LTSM package holds:
  - substate index constants (SUB_PARAM=0, SUB_CAL=1, SUB_REPAIRCLK=2, SUB_REPAIRVAL=3, SUB_REVERSALMB=4, SUB_REPAIRMB=5);
  - sequencer state encoding;
  - the 4-bit sideband message width constant.
- One sub-module: mbinit_timeout_counter (clear, enable, expired output). It is instantiated only under MBINIT_SEQ_TIMEOUT_EN.

Test Plan:
- Happy path: i_mbinit_en=1; raise i_sub_end[k] 3 cycles after o_sub_en[k] rises, for k = 0..5 -> o_sub_en steps 000001 to 111111, o_active_sub 0..5, o_mbinit_done=1 with no error; dropping i_mbinit_en returns all outputs to 0 the next edge.
- Error priority: in RUN(3) drive i_sub_err[3]=1 and i_sub_end[3]=1 in the same cycle -> ERROR, o_sub_en=0, o_train_error=1, no RUN(4).
- Timeout (TIMEOUT_CYCLES=20, macro defined): stall in RUN(2) -> o_train_error rises exactly 20 cycles after RUN(2) entry. With the macro undefined, the same stimulus stays in RUN(2) for 1000 cycles.
- TX mux: in RUN(3) drive slice 3 = 4'b0001 with valid, and slice 1 = 4'b0101 with valid -> next cycle o_tx_msg = 4'b0001, o_tx_valid = 1; slice 1 is never forwarded.
- Regression/abort: in RUN(4) drop i_sub_end[2] -> ERROR. Separately, drop i_mbinit_en in RUN(1) -> IDLE next edge. Assert rst_n=0 mid-RUN(3) -> all outputs 0 at that edge.

Source files
------------

// File: rtl/mbinit_substate_sequencer_pkg.sv
// Shared LTSM definitions for the MBINIT substate sequencer: substate indices,
// sequencer state encoding and sideband message width.
package mbinit_substate_sequencer_pkg;

  localparam int unsigned SB_MSG_W = 4;
  localparam int unsigned SubIdxW  = 3;

  localparam logic [SubIdxW-1:0] SUB_PARAM      = 3'd0;
  localparam logic [SubIdxW-1:0] SUB_CAL        = 3'd1;
  localparam logic [SubIdxW-1:0] SUB_REPAIRCLK  = 3'd2;
  localparam logic [SubIdxW-1:0] SUB_REPAIRVAL  = 3'd3;
  localparam logic [SubIdxW-1:0] SUB_REVERSALMB = 3'd4;
  localparam logic [SubIdxW-1:0] SUB_REPAIRMB   = 3'd5;

  // RUN(k) is StRun together with the registered substate index k.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StError
  } seq_state_e;

endpackage

// File: rtl/mbinit_timeout_counter.sv
// Saturating per-substate timeout counter; expired_o is high once the count
// reaches TIMEOUT_CYCLES-1.
module mbinit_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/mbinit_substate_sequencer.sv
// MBINIT substate sequencer: steps the six substates in order, muxes sideband TX
// and reports done/error. Timeout logic is built only with MBINIT_SEQ_TIMEOUT_EN.
module mbinit_substate_sequencer
  import mbinit_substate_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SUB        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic                        i_mbinit_en,
  input  logic [NUM_SUB-1:0]          i_sub_end,
  input  logic [NUM_SUB-1:0]          i_sub_err,
  input  logic [SB_MSG_W*NUM_SUB-1:0] i_sub_tx_msg,
  input  logic [NUM_SUB-1:0]          i_sub_tx_valid,
  output logic [NUM_SUB-1:0]          o_sub_en,
  output logic [SB_MSG_W-1:0]         o_tx_msg,
  output logic                        o_tx_valid,
  output logic [SubIdxW-1:0]          o_active_sub,
  output logic                        o_mbinit_done,
  output logic                        o_train_error
);

  localparam logic [SubIdxW-1:0] LastSub = SubIdxW'(NUM_SUB - 1);

  seq_state_e           state_d, state_q;
  logic [SubIdxW-1:0]   idx_d, idx_q;
  logic [NUM_SUB-1:0]   sub_en_d;
  logic [SB_MSG_W-1:0]  tx_msg_d;
  logic                 tx_valid_d;
  logic [SubIdxW-1:0]   active_d;
  logic [NUM_SUB-1:0]   le_mask, lt_mask;
  logic                 fault;
  logic                 timeout_exp;

`ifdef MBINIT_SEQ_TIMEOUT_EN
  logic timeout_clr;

  // Restart the count whenever the next cycle is not a continuation of the same RUN(k).
  assign timeout_clr = !((state_q == StRun) && (state_d == StRun) && (idx_d == idx_q));

  mbinit_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (CLK),
    .rst_ni   (rst_n),
    .clr_i    (timeout_clr),
    .en_i     (state_q == StRun),
    .expired_o(timeout_exp)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_exp    = 1'b0;
`endif

  always_comb begin
    le_mask = '0;
    lt_mask = '0;
    for (int unsigned j = 0; j < NUM_SUB; j++) begin
      le_mask[j] = (SubIdxW'(j) <= idx_q);
      lt_mask[j] = (SubIdxW'(j) < idx_q);
    end
  end

  // Errors on active/completed substates, or a completed substate dropping its end flag.
  assign fault = (|(i_sub_err & le_mask)) | (|(lt_mask & ~i_sub_end)) | timeout_exp;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!i_mbinit_en) begin
      state_d = StIdle;
      idx_d   = SUB_PARAM;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StRun;
          idx_d   = SUB_PARAM;
        end
        StRun: begin
          if (fault) begin
            state_d = StError;
          end else if (i_sub_end[idx_q]) begin
            if (idx_q == LastSub) begin
              state_d = StDone;
            end else begin
              idx_d = idx_q + SubIdxW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sub_en_d   = '0;
    tx_msg_d   = '0;
    tx_valid_d = 1'b0;
    active_d   = '0;
    case (state_d)
      StRun: begin
        active_d = idx_d;
        for (int unsigned j = 0; j < NUM_SUB; j++) begin
          sub_en_d[j] = (SubIdxW'(j) <= idx_d);
          if (SubIdxW'(j) == idx_d) begin
            tx_msg_d   = i_sub_tx_msg[j*SB_MSG_W +: SB_MSG_W];
            tx_valid_d = i_sub_tx_valid[j];
          end
        end
      end
      StDone:  sub_en_d = '1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      o_sub_en      <= '0;
      o_tx_msg      <= '0;
      o_tx_valid    <= 1'b0;
      o_active_sub  <= '0;
      o_mbinit_done <= 1'b0;
      o_train_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      o_sub_en      <= sub_en_d;
      o_tx_msg      <= tx_msg_d;
      o_tx_valid    <= tx_valid_d;
      o_active_sub  <= active_d;
      o_mbinit_done <= (state_d == StDone);
      o_train_error <= (state_d == StError);
    end
  end

endmodule

// File: tb/tb_mbinit_substate_sequencer.sv
// Self-checking bench for mbinit_substate_sequencer: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_mbinit_substate_sequencer;

  localparam int TimeoutCycles = 20;
  localparam int MIdle = 0, MRun = 1, MDone = 2, MErr = 3;
`ifdef MBINIT_SEQ_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  sub_end, sub_err, sub_val;
  logic [23:0] sub_msg;
  logic [5:0]  o_sub_en;
  logic [3:0]  o_tx_msg;
  logic        o_tx_valid;
  logic [2:0]  o_active_sub;
  logic        o_mbinit_done, o_train_error;
  logic [15:0] dut_b;

  always #5 CLK = ~CLK;

  mbinit_substate_sequencer #(
    .NUM_SUB(6),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .i_mbinit_en   (en),
    .i_sub_end     (sub_end),
    .i_sub_err     (sub_err),
    .i_sub_tx_msg  (sub_msg),
    .i_sub_tx_valid(sub_val),
    .o_sub_en      (o_sub_en),
    .o_tx_msg      (o_tx_msg),
    .o_tx_valid    (o_tx_valid),
    .o_active_sub  (o_active_sub),
    .o_mbinit_done (o_mbinit_done),
    .o_train_error (o_train_error)
  );

  assign dut_b = {o_sub_en, o_tx_msg, o_tx_valid, o_active_sub, o_mbinit_done, o_train_error};

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode, current substate and cycles spent in it.
  int          m_mode = MIdle;
  int          m_k    = 0;
  int          m_wait = 0;
  logic [15:0] m_exp  = '0;

  function automatic logic [15:0] eb(logic [5:0] s, logic [3:0] m, logic v, logic [2:0] a,
                                     logic d, logic e);
    return {s, m, v, a, d, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit rstn, input bit e_n, input logic [5:0] e,
                            input logic [5:0] r, input logic [23:0] msg, input logic [5:0] v);
    bit bad;
    logic [23:0] sh;
    if (!rstn || !e_n) begin
      m_mode = MIdle; m_k = 0; m_wait = 0;
    end else if (m_mode == MIdle) begin
      m_mode = MRun; m_k = 0; m_wait = 0;
    end else if (m_mode == MRun) begin
      bad = 1'b0;
      for (int j = 0; j <= m_k; j++) if (r[j]) bad = 1'b1;
      for (int j = 0; j < m_k; j++) if (!e[j]) bad = 1'b1;
      if (TimeoutOn && m_wait >= TimeoutCycles - 1) bad = 1'b1;
      if (bad) m_mode = MErr;
      else if (e[m_k]) begin
        if (m_k == 5) m_mode = MDone;
        else begin m_k++; m_wait = 0; end
      end else m_wait++;
    end
    if (m_mode == MRun) begin
      sh = msg >> (4 * m_k);
      m_exp = eb(6'((1 << (m_k + 1)) - 1), sh[3:0], v[m_k], 3'(m_k), 1'b0, 1'b0);
    end else if (m_mode == MDone) m_exp = eb(6'h3f, 4'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    else if (m_mode == MErr)      m_exp = eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    else                          m_exp = '0;
  endtask

  task automatic cycle(input string name, input bit rstn, input bit e_n, input logic [5:0] e,
                       input logic [5:0] r, input logic [23:0] msg, input logic [5:0] v);
    rst_n = rstn; en = e_n; sub_end = e; sub_err = r; sub_msg = msg; sub_val = v;
    model_step(rstn, e_n, e, r, msg, v);
    @(posedge CLK);
    #1;
    check(name, 32'(dut_b), 32'(m_exp));
  endtask

  task automatic advance_to(input int k);
    cycle("adv_rst", 1'b0, 1'b0, 6'h0, 6'h0, 24'h0, 6'h0);
    cycle("adv_run0", 1'b1, 1'b1, 6'h0, 6'h0, 24'h0, 6'h0);
    for (int i = 0; i < k; i++)
      cycle("adv_step", 1'b1, 1'b1, 6'((1 << (i + 1)) - 1), 6'h0, 24'h0, 6'h0);
  endtask

  typedef struct {
    logic        en;
    logic [5:0]  e;
    logic [5:0]  r;
    logic [23:0] msg;
    logic [5:0]  v;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int first;
    logic [5:0] e, r;

    tbl[0]  = '{1'b0, 6'h00, 6'h00, 24'h000000, 6'h00, eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 6'h00, 6'h00, 24'h000000, 6'h00, eb(6'h01, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[2]  = '{1'b1, 6'h01, 6'h00, 24'h000050, 6'h02, eb(6'h03, 4'h5, 1'b1, 3'd1, 1'b0, 1'b0)};
    tbl[3]  = '{1'b1, 6'h03, 6'h00, 24'h000000, 6'h00, eb(6'h07, 4'h0, 1'b0, 3'd2, 1'b0, 1'b0)};
    tbl[4]  = '{1'b1, 6'h07, 6'h10, 24'h000000, 6'h00, eb(6'h0f, 4'h0, 1'b0, 3'd3, 1'b0, 1'b0)};
    tbl[5]  = '{1'b1, 6'h07, 6'h00, 24'h001050, 6'h0a, eb(6'h0f, 4'h1, 1'b1, 3'd3, 1'b0, 1'b0)};
    tbl[6]  = '{1'b1, 6'h0f, 6'h08, 24'h000000, 6'h00, eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1)};
    tbl[7]  = '{1'b1, 6'h00, 6'h00, 24'h000000, 6'h00, eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1)};
    tbl[8]  = '{1'b0, 6'h00, 6'h00, 24'h000000, 6'h00, eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[9]  = '{1'b1, 6'h00, 6'h00, 24'h000000, 6'h00, eb(6'h01, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[10] = '{1'b1, 6'h01, 6'h00, 24'h000000, 6'h00, eb(6'h03, 4'h0, 1'b0, 3'd1, 1'b0, 1'b0)};
    tbl[11] = '{1'b0, 6'h01, 6'h00, 24'h000000, 6'h00, eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[12] = '{1'b1, 6'h00, 6'h02, 24'h000000, 6'h00, eb(6'h01, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[13] = '{1'b1, 6'h00, 6'h02, 24'h000000, 6'h00, eb(6'h01, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0)};
    tbl[14] = '{1'b1, 6'h00, 6'h01, 24'h000000, 6'h00, eb(6'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1)};

    cycle("reset", 1'b0, 1'b1, 6'h3f, 6'h3f, 24'hffffff, 6'h3f);
    check("reset_zero", 32'(dut_b), 32'h0);

    for (int i = 0; i < 15; i++) begin
      cycle($sformatf("vec%0d_model", i), 1'b1, tbl[i].en, tbl[i].e, tbl[i].r, tbl[i].msg,
            tbl[i].v);
      check($sformatf("vec%0d", i), 32'(dut_b), 32'(tbl[i].exp));
    end

    // Happy path: end flag rises on the third cycle after each enable.
    cycle("happy_rst", 1'b0, 1'b0, 6'h0, 6'h0, 24'h0, 6'h0);
    cycle("happy_run0", 1'b1, 1'b1, 6'h0, 6'h0, 24'h0, 6'h0);
    for (int k = 0; k < 6; k++) begin
      e = 6'((1 << k) - 1);
      cycle("happy_wait", 1'b1, 1'b1, e, 6'h0, 24'h0, 6'h0);
      cycle("happy_wait", 1'b1, 1'b1, e, 6'h0, 24'h0, 6'h0);
      cycle("happy_end", 1'b1, 1'b1, e | 6'(1 << k), 6'h0, 24'h0, 6'h0);
    end
    check("happy_done", 32'({o_sub_en, o_mbinit_done, o_train_error}), 32'({6'h3f, 2'b10}));
    cycle("done_hold", 1'b1, 1'b1, 6'h3f, 6'h0, 24'h0, 6'h0);
    cycle("happy_drop", 1'b1, 1'b0, 6'h3f, 6'h0, 24'h0, 6'h0);
    check("happy_idle", 32'(dut_b), 32'h0);

    // Stall in RUN(2).
    advance_to(2);
    first = -1;
    for (int i = 1; i <= 1000; i++) begin
      cycle("stall", 1'b1, 1'b1, 6'h03, 6'h0, 24'h0, 6'h0);
      if (o_train_error && first < 0) first = i;
      if (first >= 0) break;
    end
`ifdef MBINIT_SEQ_TIMEOUT_EN
    check("timeout_latency", 32'(first), 32'(TimeoutCycles));
`else
    check("no_timeout", 32'({first, 5'd0, o_active_sub}), 32'({-32'sd1, 5'd0, 3'd2}));
`endif

    advance_to(4);
    cycle("regress", 1'b1, 1'b1, 6'h0b, 6'h0, 24'h0, 6'h0);
    check("regress_err", 32'({o_train_error, o_sub_en}), 32'({1'b1, 6'h00}));

    advance_to(3);
    cycle("rst_mid", 1'b0, 1'b1, 6'h07, 6'h0, 24'hffffff, 6'h3f);
    check("rst_mid_zero", 32'(dut_b), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      e = 6'($urandom);
      r = ($urandom_range(0, 99) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h0;
      if (m_mode == MRun) begin
        e = (e & ~6'((1 << (m_k + 1)) - 1)) | 6'((1 << m_k) - 1);
        if ($urandom_range(0, 99) < 30) e[m_k] = 1'b1;
        if (m_k > 0 && $urandom_range(0, 99) < 2) e[$urandom_range(0, m_k - 1)] = 1'b0;
      end
      cycle("random", $urandom_range(0, 199) != 0, $urandom_range(0, 99) >= 3, e, r,
            24'($urandom), 6'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
